// File: rtl/mem_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mem_ctrl_pkg : FSM state encodings and access-size codes for mem_ctrl (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

package mem_ctrl_pkg;

    localparam logic [1:0] MC_IDLE = 2'd0;
    localparam logic [1:0] MC_RD   = 2'd1;
    localparam logic [1:0] MC_WR   = 2'd2;
    localparam logic [1:0] MC_DONE = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Size code 11 is treated as a full word.
    function automatic logic [2:0] size_len(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            SZ_WORD: return 3'd4;
            default: return 3'd4;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_ctrl.sv
// ----------------------------------------------------------------------------
// mem_ctrl : arbitrates fetch/load-store onto the byte-wide memory port (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int         ADDR_WIDTH = 32,
    parameter logic [1:0] IO_PREFIX  = 2'b11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    input  logic                  if_flush_i,
    output logic                  if_done_o,
    output logic [31:0]           if_rdata_o,
    input  logic                  mem_req_i,
    input  logic                  mem_we_i,
    input  logic [1:0]            mem_size_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [31:0]           mem_wdata_i,
    output logic                  mem_done_o,
    output logic [31:0]           mem_rdata_o,
    output logic                  mc_stall_o,
    output logic [ADDR_WIDTH-1:0] mem_a_o,
    output logic [7:0]            mem_dout_o,
    output logic                  mem_wr_o,
    input  logic [7:0]            mem_din_i,
    input  logic                  io_buffer_full_i
);

    logic [1:0]            state_q, state_d;
    logic                  owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            len_q, len_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0] a_q, a_d;
    logic [7:0]            dout_q, dout_d;
    logic                  wr_q, wr_d;
    logic                  if_done_q, if_done_d;
    logic                  mem_done_q, mem_done_d;
    logic [1:0]            sidx;

    // In RD, cnt is the cycle number since grant; read data lags its address by two cycles.
    assign sidx = 2'(cnt_q - 3'd2);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        a_d        = '0;
        dout_d     = '0;
        wr_d       = 1'b0;
        if_done_d  = 1'b0;
        mem_done_d = 1'b0;

        unique case (state_q)
            MC_IDLE: begin
                if (mem_req_i) begin
                    owner_d = 1'b1;
                    addr_d  = mem_addr_i;
                    len_d   = size_len(mem_size_i);
                    wdata_d = mem_wdata_i;
                    rdata_d = '0;
                    a_d     = mem_addr_i;
                    if (mem_we_i) begin
                        state_d = MC_WR;
                        if (io_buffer_full_i && (mem_addr_i[17:16] == IO_PREFIX)) begin
                            cnt_d = 3'd0;
                        end else begin
                            cnt_d  = 3'd1;
                            wr_d   = 1'b1;
                            dout_d = mem_wdata_i[7:0];
                        end
                    end else begin
                        state_d = MC_RD;
                        cnt_d   = 3'd1;
                    end
                end else if (if_req_i && !if_flush_i) begin
                    owner_d = 1'b0;
                    addr_d  = if_addr_i;
                    len_d   = 3'd4;
                    rdata_d = '0;
                    a_d     = if_addr_i;
                    state_d = MC_RD;
                    cnt_d   = 3'd1;
                end
            end
            MC_RD: begin
                if (!owner_q && if_flush_i) begin
                    state_d = MC_IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    if (cnt_q >= 3'd2) begin
                        rdata_d[{sidx, 3'b000} +: 8] = mem_din_i;
                    end
                    if (cnt_q < len_q) begin
                        a_d = addr_q + ADDR_WIDTH'(cnt_q);
                    end
                    if (cnt_q == len_q + 3'd1) begin
                        state_d    = MC_DONE;
                        cnt_d      = 3'd0;
                        mem_done_d = owner_q;
                        if_done_d  = !owner_q;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            MC_WR: begin
                if (cnt_q == len_q) begin
                    state_d    = MC_DONE;
                    cnt_d      = 3'd0;
                    mem_done_d = 1'b1;
                end else begin
                    // A throttled byte keeps its address on the bus without a strobe.
                    a_d = addr_q + ADDR_WIDTH'(cnt_q);
                    if (!(io_buffer_full_i && (addr_q[17:16] == IO_PREFIX))) begin
                        wr_d   = 1'b1;
                        dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                        cnt_d  = cnt_q + 3'd1;
                    end
                end
            end
            MC_DONE: begin
                state_d = MC_IDLE;
            end
            default: begin
                state_d = MC_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= MC_IDLE;
            owner_q    <= 1'b0;
            addr_q     <= '0;
            len_q      <= 3'd0;
            cnt_q      <= 3'd0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            a_q        <= '0;
            dout_q     <= '0;
            wr_q       <= 1'b0;
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            a_q        <= a_d;
            dout_q     <= dout_d;
            wr_q       <= wr_d;
            if_done_q  <= if_done_d;
            mem_done_q <= mem_done_d;
        end
    end

    assign if_done_o   = if_done_q;
    assign if_rdata_o  = rdata_q;
    assign mem_done_o  = mem_done_q;
    assign mem_rdata_o = rdata_q;
    assign mem_a_o     = a_q;
    assign mem_dout_o  = dout_q;
    assign mem_wr_o    = wr_q;
    assign mc_stall_o  = mem_req_i & ~mem_done_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mem_ctrl : directed scoreboard bench for mem_ctrl with a 1-cycle-latency byte memory (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_flush_i;
    logic        if_done_o;
    logic [31:0] if_rdata_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [1:0]  mem_size_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic        mem_done_o;
    logic [31:0] mem_rdata_o;
    logic        mc_stall_o;
    logic [31:0] mem_a_o;
    logic [7:0]  mem_dout_o;
    logic        mem_wr_o;
    logic [7:0]  mem_din_i;
    logic        io_buffer_full_i;

    mem_ctrl #(
        .ADDR_WIDTH(32),
        .IO_PREFIX (2'b11)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .if_req_i        (if_req_i),
        .if_addr_i       (if_addr_i),
        .if_flush_i      (if_flush_i),
        .if_done_o       (if_done_o),
        .if_rdata_o      (if_rdata_o),
        .mem_req_i       (mem_req_i),
        .mem_we_i        (mem_we_i),
        .mem_size_i      (mem_size_i),
        .mem_addr_i      (mem_addr_i),
        .mem_wdata_i     (mem_wdata_i),
        .mem_done_o      (mem_done_o),
        .mem_rdata_o     (mem_rdata_o),
        .mc_stall_o      (mc_stall_o),
        .mem_a_o         (mem_a_o),
        .mem_dout_o      (mem_dout_o),
        .mem_wr_o        (mem_wr_o),
        .mem_din_i       (mem_din_i),
        .io_buffer_full_i(io_buffer_full_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_mem;
        bit          chk_data;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  mem [logic [31:0]];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: external memory responds one cycle after the address, then the
    // scoreboard matches any done pulse and the requester drops its request.
    task automatic step();
        logic [31:0] a;
        logic        w;
        logic [7:0]  d;
        exp_t        e;
        a = mem_a_o;
        w = mem_wr_o;
        d = mem_dout_o;
        @(posedge clk);
        #1;
        cyc++;
        if (w) mem[a] = d;
        mem_din_i = mem.exists(a) ? mem[a] : 8'h00;
        if (if_done_o || mem_done_o) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", {30'd0, mem_done_o, if_done_o}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
                chk("done_owner", {31'd0, mem_done_o}, {31'd0, e.is_mem});
                if (e.chk_data) chk("rdata", e.is_mem ? mem_rdata_o : if_rdata_o, e.data);
                if (e.is_mem) begin
                    chk("stall_at_done", {31'd0, mc_stall_o}, 32'd0);
                    mem_req_i = 1'b0;
                end else begin
                    if_req_i = 1'b0;
                end
            end
        end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
            chk("missed_done", 32'(cyc), 32'(sb[0].cyc));
            void'(sb.pop_front());
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        step();
        step();
    endtask

    initial begin
        int t0;
        rst              = 1'b0;
        if_req_i         = 1'b0;
        if_addr_i        = '0;
        if_flush_i       = 1'b0;
        mem_req_i        = 1'b0;
        mem_we_i         = 1'b0;
        mem_size_i       = 2'b00;
        mem_addr_i       = '0;
        mem_wdata_i      = '0;
        mem_din_i        = '0;
        io_buffer_full_i = 1'b0;

        mem[32'h100] = 8'h13; mem[32'h101] = 8'h05; mem[32'h102] = 8'h10; mem[32'h103] = 8'h00;
        mem[32'h000] = 8'hEF; mem[32'h001] = 8'hBE; mem[32'h002] = 8'hAD; mem[32'h003] = 8'hDE;
        mem[32'h200] = 8'h11; mem[32'h201] = 8'h22; mem[32'h202] = 8'h33; mem[32'h203] = 8'h44;
        mem[32'h1001] = 8'h34; mem[32'h1002] = 8'h12; mem[32'h1003] = 8'h99;

        step();
        step();
        chk("rst_a",        mem_a_o, 32'h0);
        chk("rst_wr",       {31'd0, mem_wr_o}, 32'd0);
        chk("rst_dout",     {24'd0, mem_dout_o}, 32'd0);
        chk("rst_if_done",  {31'd0, if_done_o}, 32'd0);
        chk("rst_mem_done", {31'd0, mem_done_o}, 32'd0);
        chk("rst_rdata",    mem_rdata_o, 32'h0);
        rst = 1'b1;
        step();

        // Fetch at 0x100
        t0 = cyc;
        if_req_i  = 1'b1;
        if_addr_i = 32'h100;
        sb.push_back('{is_mem: 1'b0, chk_data: 1'b1, data: 32'h00100513, cyc: t0 + 6});
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("fetch_addr", mem_a_o, 32'h100 + 32'(k - 1));
        end
        drain();

        // Simultaneous fetch and byte store: store wins
        t0 = cyc;
        if_req_i    = 1'b1;
        if_addr_i   = 32'h0;
        mem_req_i   = 1'b1;
        mem_we_i    = 1'b1;
        mem_size_i  = 2'b00;
        mem_addr_i  = 32'h2000;
        mem_wdata_i = 32'h123456AB;
        sb.push_back('{is_mem: 1'b1, chk_data: 1'b0, data: 32'h0, cyc: t0 + 2});
        sb.push_back('{is_mem: 1'b0, chk_data: 1'b1, data: 32'hDEADBEEF, cyc: t0 + 9});
        step();
        chk("st_wr",    {31'd0, mem_wr_o}, 32'd1);
        chk("st_dout",  {24'd0, mem_dout_o}, 32'hAB);
        chk("st_addr",  mem_a_o, 32'h2000);
        chk("st_stall", {31'd0, mc_stall_o}, 32'd1);
        step();
        step();
        step();
        chk("if_after_st_addr", mem_a_o, 32'h0);
        chk("st_mem_written", {24'd0, mem.exists(32'h2000) ? mem[32'h2000] : 8'h00}, 32'hAB);
        drain();

        // Flush mid-fetch, then a new fetch
        t0 = cyc;
        if_req_i  = 1'b1;
        if_addr_i = 32'h100;
        step();
        step();
        step();
        if_flush_i = 1'b1;
        step();
        if_flush_i = 1'b0;
        chk("flush_a_zero",  mem_a_o, 32'h0);
        chk("flush_no_done", {31'd0, if_done_o}, 32'd0);
        if_addr_i = 32'h200;
        sb.push_back('{is_mem: 1'b0, chk_data: 1'b1, data: 32'h44332211, cyc: t0 + 10});
        step();
        chk("refetch_addr", mem_a_o, 32'h200);
        drain();

        // Half load at 0x1001
        t0 = cyc;
        mem_req_i  = 1'b1;
        mem_we_i   = 1'b0;
        mem_size_i = 2'b01;
        mem_addr_i = 32'h1001;
        sb.push_back('{is_mem: 1'b1, chk_data: 1'b1, data: 32'h00001234, cyc: t0 + 4});
        step();
        chk("half_addr0", mem_a_o, 32'h1001);
        step();
        chk("half_addr1", mem_a_o, 32'h1002);
        drain();

        // Throttled I/O byte store
        t0 = cyc;
        mem_req_i        = 1'b1;
        mem_we_i         = 1'b1;
        mem_size_i       = 2'b00;
        mem_addr_i       = 32'h30000;
        mem_wdata_i      = 32'h0000005A;
        io_buffer_full_i = 1'b1;
        sb.push_back('{is_mem: 1'b1, chk_data: 1'b0, data: 32'h0, cyc: t0 + 5});
        step();
        chk("io_wr_c1", {31'd0, mem_wr_o}, 32'd0);
        step();
        chk("io_wr_c2", {31'd0, mem_wr_o}, 32'd0);
        chk("io_hold_addr", mem_a_o, 32'h30000);
        step();
        io_buffer_full_i = 1'b0;
        chk("io_wr_c3", {31'd0, mem_wr_o}, 32'd0);
        step();
        chk("io_wr_c4", {31'd0, mem_wr_o}, 32'd1);
        chk("io_dout_c4", {24'd0, mem_dout_o}, 32'h5A);
        drain();

        // Asynchronous reset during a fetch, then restart
        t0 = cyc;
        if_req_i  = 1'b1;
        if_addr_i = 32'h100;
        step();
        step();
        step();
        chk("pre_rst_addr", mem_a_o, 32'h102);
        rst = 1'b0;
        #1;
        chk("arst_a",  mem_a_o, 32'h0);
        chk("arst_wr", {31'd0, mem_wr_o}, 32'd0);
        chk("arst_rdata", if_rdata_o, 32'h0);
        step();
        rst = 1'b1;
        t0 = cyc;
        sb.push_back('{is_mem: 1'b0, chk_data: 1'b1, data: 32'h00100513, cyc: t0 + 6});
        step();
        chk("restart_addr", mem_a_o, 32'h100);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
